pipe_stage_buf: RTL

- Parametrised inter-stage pipeline buffer that generalises the fixed-field stage registers (XM/MW style) into one reusable block.
- Carries an opaque control word and an opaque data word through a DEPTH-entry buffer with a valid/ready handshake, synchronous flush, and bubble insertion (zeroed control on empty).
- Sits between any two pipeline stages. DEPTH=2 breaks the combinational ready path from downstream stalls.

---
 rtl/pipe_stage_buf_pkg.sv | 42 ++++
 rtl/pipe_sat_counter.sv | 23 ++
 rtl/pipe_stage_buf.sv | 120 ++++++++++++
 3 files changed

// File: rtl/pipe_stage_buf_pkg.sv
// Shared types for the generic inter-stage pipeline buffer and the stage
// payload structs that get packed into its opaque ctrl/data words.
package pipe_stage_buf_pkg;

    localparam int PIPE_DEPTH_MAX = 4;
    localparam int PIPE_CNT_W_DEF = 16;

    typedef logic [2:0]                occ_t;
    typedef logic [PIPE_CNT_W_DEF-1:0] bubble_cnt_t;
    typedef logic [7:0]                pipe_ctrl_t;

    // X->M and M->W payloads; each ctrl struct is 8 bits, each data struct 64.
    typedef struct packed {
        logic       reg_wr;
        logic       mem_rd;
        logic       mem_wr;
        logic [4:0] rd;
    } xm_ctrl_t;

    typedef struct packed {
        logic [31:0] alu_res;
        logic [31:0] store_val;
    } xm_data_t;

    typedef struct packed {
        logic       reg_wr;
        logic       wb_sel;
        logic [4:0] rd;
        logic       rsvd;
    } mw_ctrl_t;

    typedef struct packed {
        logic [31:0] alu_res;
        logic [31:0] mem_rdata;
    } mw_data_t;

    // The all-zero control word is the bubble/NOP encoding.
    function automatic pipe_ctrl_t pipe_nop_ctrl();
        return '0;
    endfunction

endpackage

// File: rtl/pipe_sat_counter.sv
// Saturating up-counter; holds at all-ones until the next reset.
module pipe_sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_inc,
    output logic [W-1:0] o_count
);

    logic [W-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_inc && (r_count != '1)) begin
            r_count <= r_count + W'(1);
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/pipe_stage_buf.sv
// Generic DEPTH-entry pipeline stage buffer: valid/ready handshake, flush,
// zeroed-ctrl bubbles when empty and a starved-cycle counter.
module pipe_stage_buf
    import pipe_stage_buf_pkg::*;
#(
    parameter int CTRL_W    = 8,
    parameter int DATA_W    = 64,
    parameter int DEPTH     = 2,
    parameter int ZERO_IDLE = 1,
    parameter int CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [2:0]        occupancy,
    output logic [CNT_W-1:0]  bubble_cnt
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [CTRL_W-1:0] r_ctrl [DEPTH];
    logic [DATA_W-1:0] r_data [DEPTH];
    logic [PTR_W-1:0]  r_wptr;
    logic [PTR_W-1:0]  r_rptr;
    occ_t              r_occ;

    logic              w_push;
    logic              w_pop;
    logic              w_valid;
    logic [CTRL_W-1:0] w_head_ctrl;
    logic [DATA_W-1:0] w_head_data;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    generate
        if (DEPTH == 1) begin : g_ready_pass
            // Single entry: allow push into the slot being popped the same cycle.
            assign in_ready    = (r_occ == 3'd0) | out_ready;
            assign w_head_ctrl = r_ctrl[0];
            assign w_head_data = r_data[0];
        end else begin : g_ready_reg
            assign in_ready    = (r_occ < 3'(DEPTH));
            assign w_head_ctrl = r_ctrl[r_rptr];
            assign w_head_data = r_data[r_rptr];
        end
    endgenerate

    assign w_valid = (r_occ != 3'd0);
    assign w_push  = in_valid & in_ready & ~flush;
    assign w_pop   = w_valid & out_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_ctrl[i] <= '0;
                r_data[i] <= '0;
            end
        end else if (flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_ctrl[i] <= CTRL_W'(pipe_nop_ctrl());
            end
        end else if (w_push) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (r_wptr == PTR_W'(i)) begin
                    r_ctrl[i] <= in_ctrl;
                    r_data[i] <= in_data;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_occ  <= '0;
        end else if (flush) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_occ  <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= ptr_inc(r_wptr);
            end
            if (w_pop) begin
                r_rptr <= ptr_inc(r_rptr);
            end
            if (w_push && !w_pop) begin
                r_occ <= r_occ + 3'd1;
            end else if (w_pop && !w_push) begin
                r_occ <= r_occ - 3'd1;
            end
        end
    end

    assign out_valid = w_valid;
    assign out_ctrl  = w_valid ? w_head_ctrl : CTRL_W'(pipe_nop_ctrl());
    assign out_data  = (w_valid || (ZERO_IDLE == 0)) ? w_head_data : '0;
    assign occupancy = r_occ;

    pipe_sat_counter #(
        .W (CNT_W)
    ) u_bubble_cnt (
        .clk     (clk),
        .rst_n   (rst),
        .i_inc   (out_ready & ~w_valid),
        .o_count (bubble_cnt)
    );

endmodule
